aes_decrypt_seq: RTL and testbench

Iterative AES-128 decryption sequencer. It replaces the fully unrolled ten-round decrypt datapath with a single shared inverse-round unit, time-multiplexed over 11 cycles. Round keys come from an external round-key store, addressed by round index. The block sits between the encrypted-template source and the fingerprint matcher, and it exchanges blocks with both over valid/ready handshakes.

---
 rtl/aes_pkg.sv | 101 ++++++++++
 rtl/aes_inv_round_unit.sv | 26 ++
 rtl/aes_decrypt_seq.sv | 100 ++++++++++
 tb/tb_aes_decrypt_seq.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) inverse-cipher transforms for the iterative AES-128 decryptor.
// Byte i of a block sits at bits [127-8*i -: 8]; column c holds bytes 4c..4c+3.
package aes_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StRound,
    StFinal,
    StDone
  } dec_state_e;

  typedef enum logic [1:0] {
    ModeFirst,
    ModeMid,
    ModeLast
  } round_mode_e;

  typedef logic [127:0] block_t;

  localparam int unsigned AES_ROUNDS = 10;
  localparam int unsigned RND_W      = 4;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = gf_xtime(sh);
    end
    return acc;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8); zero maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] res;
    logic [7:0] sq;
    res = 8'h01;
    sq  = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) res = gf_mul(res, sq);
      sq = gf_mul(sq, sq);
    end
    return res;
  endfunction

  // Inverse affine map followed by field inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

  function automatic block_t inv_sub_bytes(input block_t s);
    block_t res;
    res = '0;
    for (int i = 0; i < 16; i++) begin
      res[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    end
    return res;
  endfunction

  function automatic block_t inv_shift_rows(input block_t s);
    block_t res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
    return res;
  endfunction

  function automatic block_t inv_mix_columns(input block_t s);
    block_t     res;
    logic [7:0] a0, a1, a2, a3;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-8*(4*c)   -: 8];
      a1 = s[127-8*(4*c+1) -: 8];
      a2 = s[127-8*(4*c+2) -: 8];
      a3 = s[127-8*(4*c+3) -: 8];
      res[127-8*(4*c)   -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^
                                gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      res[127-8*(4*c+1) -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^
                                gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      res[127-8*(4*c+2) -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^
                                gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      res[127-8*(4*c+3) -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^
                                gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_inv_round_unit.sv
// Combinational inverse-round unit shared across all rounds of the decrypt sequencer.
// The key add is folded to the front so every mode starts from state ^ round_key.
module aes_inv_round_unit
  import aes_pkg::*;
(
  input  block_t      state,
  input  block_t      round_key,
  input  round_mode_e mode,
  output block_t      next_state
);

  block_t keyed;

  assign keyed = state ^ round_key;

  always_comb begin
    next_state = keyed;
    unique case (mode)
      ModeFirst: next_state = inv_sub_bytes(inv_shift_rows(keyed));
      ModeMid:   next_state = inv_sub_bytes(inv_shift_rows(inv_mix_columns(keyed)));
      ModeLast:  next_state = keyed;
      default:   next_state = keyed;
    endcase
  end

endmodule

// File: rtl/aes_decrypt_seq.sv
// Iterative AES-128 decrypt sequencer: one inverse-round unit reused over 11 cycles,
// round keys fetched combinationally from an external store addressed by round_idx.
module aes_decrypt_seq
  import aes_pkg::*;
#(
  parameter int unsigned ROUNDS = AES_ROUNDS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic [RND_W-1:0] round_idx,
  input  logic [127:0]     round_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic [31:0]      out_word,
  output logic             busy
);

  dec_state_e       st_q, st_d;
  logic [RND_W-1:0] rnd_q, rnd_d;
  block_t           blk_q, blk_d;
  // Holds in_ready low until the first clock edge after reset release.
  logic             armed_q;

  round_mode_e      mode;
  block_t           ru_next;

  aes_inv_round_unit u_round (
    .state      (blk_q),
    .round_key  (round_key),
    .mode       (mode),
    .next_state (ru_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= StIdle;
      rnd_q   <= RND_W'(ROUNDS);
      blk_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      rnd_q   <= rnd_d;
      blk_q   <= blk_d;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    st_d  = st_q;
    rnd_d = rnd_q;
    blk_d = blk_q;
    mode  = ModeMid;
    unique case (st_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          blk_d = in_data;
          rnd_d = RND_W'(ROUNDS);
          st_d  = StInit;
        end
      end
      StInit: begin
        mode  = ModeFirst;
        blk_d = ru_next;
        rnd_d = rnd_q - RND_W'(1);
        st_d  = StRound;
      end
      StRound: begin
        mode  = ModeMid;
        blk_d = ru_next;
        if (rnd_q == RND_W'(1)) begin
          rnd_d = '0;
          st_d  = StFinal;
        end else begin
          rnd_d = rnd_q - RND_W'(1);
        end
      end
      StFinal: begin
        mode  = ModeLast;
        blk_d = ru_next;
        st_d  = StDone;
      end
      StDone: begin
        if (out_ready) st_d = StIdle;
      end
      default: st_d = StIdle;
    endcase
  end

  assign in_ready  = (st_q == StIdle) && armed_q;
  assign out_valid = (st_q == StDone);
  assign busy      = (st_q != StIdle);
  assign round_idx = rnd_q;
  assign out_data  = blk_q;
  assign out_word  = blk_q[31:0];

endmodule

// File: tb/tb_aes_decrypt_seq.sv
// Bench for aes_decrypt_seq: a forward AES-128 model encrypts random plaintexts and
// supplies the key store; the DUT must return the original plaintext.
module tb_aes_decrypt_seq;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   round_idx;
  logic [127:0] round_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [31:0]  out_word;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] rk     [0:10];

  aes_decrypt_seq #(.ROUNDS(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .round_idx (round_idx),
    .round_key (round_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_word  (out_word),
    .busy      (busy)
  );

  assign round_key = (round_idx <= 4'd10) ? rk[round_idx] : 128'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] b_xt(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] b_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = b_xt(a);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (b_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = b_xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] blk;
    blk = pt ^ rk[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[blk[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[4*c+rr] = s[4*((c+rr)%4)+rr];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r != 10) begin
          s[4*c]   = b_mul(a0, 8'h02) ^ b_mul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ b_mul(a1, 8'h02) ^ b_mul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ b_mul(a2, 8'h02) ^ b_mul(a3, 8'h03);
          s[4*c+3] = b_mul(a0, 8'h03) ^ a1 ^ a2 ^ b_mul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = s[i];
      blk = blk ^ rk[r];
    end
    return blk;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Offers ct, then returns once out_valid is seen (lat = edges after acceptance, capped).
  task automatic send_and_wait(input logic [127:0] ct, output logic [127:0] got,
                               output int lat);
    int n;
    n = 0;
    in_data  = ct;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
    in_data  = rand128();
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    got = out_data;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    #12;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b000)
      begin errors++; $display("FAIL reset_ctrl: got %b want 000", {in_ready, out_valid, busy}); end
    checks++;
    if (out_data !== 128'h0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
    checks++;
    if (out_word !== 32'h0) begin errors++; $display("FAIL reset_word: got %h want 0", out_word); end
    checks++;
    if (round_idx !== 4'd10) begin errors++; $display("FAIL reset_idx: got %0d want 10", round_idx); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0)
      begin errors++; $display("FAIL ready_before_edge: got %b want 0", in_ready); end
    tick();
    checks++;
    if (in_ready !== 1'b1)
      begin errors++; $display("FAIL ready_after_edge: got %b want 1", in_ready); end
  endtask

  task automatic test_fips_vector();
    logic [127:0] pt, ct;
    int n;
    pt = 128'h00112233445566778899aabbccddeeff;
    ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    expand_key(128'h000102030405060708090a0b0c0d0e0f);
    in_data  = ct;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin tick(); n++; end
    tick();
    in_valid = 1'b0;
    in_data  = rand128();
    for (int k = 0; k < 11; k++) begin
      checks++;
      if (round_idx !== 4'(10 - k))
        begin errors++; $display("FAIL fips_idx[%0d]: got %0d want %0d", k, round_idx, 10 - k); end
      checks++;
      if ({busy, out_valid} !== 2'b10)
        begin errors++; $display("FAIL fips_busy[%0d]: got %b want 10", k, {busy, out_valid}); end
      tick();
    end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL fips_latency: valid %b want 1", out_valid); end
    checks++;
    if (out_data !== pt) begin errors++; $display("FAIL fips_data: got %h want %h", out_data, pt); end
    checks++;
    if (out_word !== 32'hccddeeff)
      begin errors++; $display("FAIL fips_word: got %h want ccddeeff", out_word); end
    tick();
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b100)
      begin errors++; $display("FAIL fips_release: got %b want 100", {in_ready, busy, out_valid}); end
  endtask

  task automatic test_random_vectors();
    logic [127:0] pt, got;
    int lat;
    for (int v = 0; v < 4; v++) begin
      expand_key(rand128());
      pt = rand128();
      send_and_wait(encrypt(pt), got, lat);
      checks++;
      if (lat !== 11) begin errors++; $display("FAIL rand_lat[%0d]: got %0d want 11", v, lat); end
      checks++;
      if (got !== pt) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", v, got, pt); end
      tick();
    end
  endtask

  task automatic test_back_pressure();
    logic [127:0] pt, got;
    int lat;
    expand_key(rand128());
    pt = rand128();
    out_ready = 1'b0;
    send_and_wait(encrypt(pt), got, lat);
    checks++;
    if (lat !== 11 || got !== pt)
      begin errors++; $display("FAIL bp_first: lat %0d data %h want 11 %h", lat, got, pt); end
    in_valid = 1'b1;
    in_data  = rand128();
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if ({out_valid, in_ready, busy} !== 3'b101 || out_data !== pt)
        begin
          errors++;
          $display("FAIL bp_hold[%0d]: ctl %b data %h want 101 %h", k,
                   {out_valid, in_ready, busy}, out_data, pt);
        end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b100)
      begin errors++; $display("FAIL bp_release: got %b want 100", {in_ready, busy, out_valid}); end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [127:0] pt [2];
    logic [127:0] ct [2];
    logic [127:0] got [$];
    int acc_cyc [2];
    int acc_n;
    bit accept_now;
    expand_key(rand128());
    for (int i = 0; i < 2; i++) begin
      pt[i] = rand128();
      ct[i] = encrypt(pt[i]);
    end
    acc_n     = 0;
    out_ready = 1'b1;
    in_data   = ct[0];
    in_valid  = 1'b1;
    for (int n = 0; n < 60 && got.size() < 2; n++) begin
      accept_now = 1'b0;
      if (out_valid === 1'b1) got.push_back(out_data);
      if (in_valid === 1'b1 && in_ready === 1'b1 && acc_n < 2) begin
        acc_cyc[acc_n] = cyc;
        acc_n++;
        accept_now = 1'b1;
      end
      tick();
      if (accept_now) begin
        if (acc_n == 1) in_data = ct[1];
        else begin in_data = rand128(); in_valid = 1'b0; end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got.size() !== 2 || acc_n !== 2)
      begin errors++; $display("FAIL b2b_count: outs %0d accepts %0d want 2 2", got.size(), acc_n); end
    else begin
      checks++;
      if (got[0] !== pt[0]) begin errors++; $display("FAIL b2b_first: got %h want %h", got[0], pt[0]); end
      checks++;
      if (got[1] !== pt[1]) begin errors++; $display("FAIL b2b_second: got %h want %h", got[1], pt[1]); end
      checks++;
      if (acc_cyc[1] - acc_cyc[0] !== 13)
        begin errors++; $display("FAIL b2b_spacing: got %0d want 13", acc_cyc[1] - acc_cyc[0]); end
    end
    tick();
  endtask

  task automatic test_mid_reset();
    logic [127:0] pt, got;
    int lat, n;
    bit pulse;
    expand_key(rand128());
    pt = rand128();
    in_data  = encrypt(pt);
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin tick(); n++; end
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b000)
      begin errors++; $display("FAIL mrst_ctrl: got %b want 000", {in_ready, out_valid, busy}); end
    checks++;
    if (out_data !== 128'h0 || out_word !== 32'h0)
      begin errors++; $display("FAIL mrst_data: got %h %h want 0 0", out_data, out_word); end
    checks++;
    if (round_idx !== 4'd10) begin errors++; $display("FAIL mrst_idx: got %0d want 10", round_idx); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulse = 1'b0;
    repeat (15) begin
      tick();
      if (out_valid === 1'b1) pulse = 1'b1;
    end
    checks++;
    if (pulse !== 1'b0) begin errors++; $display("FAIL mrst_no_output: got %b want 0", pulse); end
    expand_key(rand128());
    pt = rand128();
    send_and_wait(encrypt(pt), got, lat);
    checks++;
    if (lat !== 11 || got !== pt)
      begin errors++; $display("FAIL mrst_recover: lat %0d data %h want 11 %h", lat, got, pt); end
    tick();
  endtask

  task automatic test_input_isolation();
    logic [127:0] pt;
    int n, stray;
    bit idle_ok;
    expand_key(rand128());
    pt = rand128();
    in_data  = encrypt(pt);
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin tick(); n++; end
    tick();
    stray = 0;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = rand128();
      if (in_ready === 1'b1) stray++;
      tick();
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL iso_ready: got %0d want 0", stray); end
    checks++;
    if (n !== 11) begin errors++; $display("FAIL iso_latency: got %0d want 11", n); end
    checks++;
    if (out_data !== pt) begin errors++; $display("FAIL iso_data: got %h want %h", out_data, pt); end
    tick();
    idle_ok = 1'b1;
    repeat (3) begin
      if (busy !== 1'b0) idle_ok = 1'b0;
      tick();
    end
    checks++;
    if (idle_ok !== 1'b1) begin errors++; $display("FAIL iso_no_extra: got %b want 1", idle_ok); end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_vector();
    test_random_vectors();
    test_back_pressure();
    test_back_to_back();
    test_mid_reset();
    test_input_isolation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
